// File: rtl/doodlejump_soc_pulse_out.sv
// Avalon-MM output port with a level data register and hardware-timed strobes.
// Optional BITSET/BITCLR register at address 3: define DOODLEJUMP_SOC_PULSE_OUT_BITSET_EN.
module doodlejump_soc_pulse_out #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_LEN   = 2'd1;
  localparam logic [1:0] ADDR_GO    = 2'd2;
  localparam logic [1:0] ADDR_BITOP = 2'd3;

  logic [WIDTH-1:0] data_reg;
  logic [15:0]      len_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [15:0]      cnt;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             busy;
  logic             go_en;

  assign wr_en = chipselect & ~write_n;
  assign busy  = (cnt != 16'd0);
  // A zero pulse length makes GO a no-op, so nothing downstream ever sees it.
  assign go_en = wr_en && (address == ADDR_GO) && (len_reg != 16'd0);

  assign out_port = data_reg | (mask_reg & {WIDTH{busy}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= '0;
    end else if (wr_en && address == ADDR_DATA) begin
      data_reg <= writedata[WIDTH-1:0];
    end
`ifdef DOODLEJUMP_SOC_PULSE_OUT_BITSET_EN
    else if (wr_en && address == ADDR_BITOP) begin
      if (writedata[31])
        data_reg <= data_reg | writedata[WIDTH-1:0];
      else
        data_reg <= data_reg & ~writedata[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_reg <= 16'd0;
    end else if (wr_en && address == ADDR_LEN) begin
      len_reg <= writedata[15:0];
    end
  end

  // Reload has priority over the decrement, so a GO on the final pulse
  // cycle extends the pulse seamlessly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
      cnt      <= 16'd0;
    end else if (go_en) begin
      mask_reg <= writedata[WIDTH-1:0];
      cnt      <= len_reg;
    end else if (busy) begin
      cnt      <= cnt - 16'd1;
    end
  end

  always_comb begin
    rd_next = 32'd0;
    case (address)
      ADDR_DATA:  rd_next = {{(32-WIDTH){1'b0}}, out_port};
      ADDR_LEN:   rd_next = {16'd0, len_reg};
      ADDR_GO:    rd_next = {cnt, 15'd0, busy};
      ADDR_BITOP: rd_next = 32'd0;
      default:    rd_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= 32'd0;
    else
      readdata <= rd_next;
  end

endmodule
